// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its CNN stage chain.
// Combinational wiring only, so it adds no latency.
// Stages hold their complete level until seen; the sequencer never stalls them.
interface layer_sequencer_if #(
  parameter int NUM_LAYERS = 8
);
  logic                  start;
  logic                  abort;
  logic [NUM_LAYERS-1:0] layer_complete;
  logic [NUM_LAYERS-1:0] layer_begin;
  logic [3:0]            cur_layer;
  logic                  busy;
  logic                  done;
  logic                  error;

  // Controller side: issues run requests, reports stage completions.
  modport master (
    output start, abort, layer_complete,
    input  layer_begin, cur_layer, busy, done, error
  );

  // Sequencer side.
  modport slave (
    input  start, abort, layer_complete,
    output layer_begin, cur_layer, busy, done, error
  );
endinterface

// File: rtl/layer_sequencer.sv
// In-order scheduler that raises each CNN stage's begin level and watches its complete level.
// Latency: begin rises 1 cycle after an accepted start; begin drops 1 cycle after complete.
// No backpressure: complete is a level, latched into done_mask; start is ignored while busy.
module layer_sequencer #(
  parameter int              NUM_LAYERS = 8,
  parameter int              OVERLAP    = 1,
  parameter int              TO_W       = 20,
  parameter logic [TO_W-1:0] TIMEOUT    = 20'hFFFFF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  layer_sequencer_if.slave    seq_io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            head_q, head_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [NUM_LAYERS-1:0] begin_q, begin_d;
  logic [TO_W-1:0]       wd_q, wd_d;
  logic                  error_q, error_d;

  // Scratch values used while evaluating a RUN cycle.
  logic [3:0]            new_head;
  logic                  scan_stop;
  logic [TO_W-1:0]       wd_inc;

  // Stages that may run right now: the head, plus head+1 when overlapping,
  // never past the last stage.
  function automatic logic [NUM_LAYERS-1:0] armed_set(input logic [3:0] h);
    logic [NUM_LAYERS-1:0] a;
    a = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (k == int'(h) || (OVERLAP != 0 && k == int'(h) + 1)) begin
        a[k] = 1'b1;
      end
    end
    return a;
  endfunction

  // State register; reset wins over every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      mask_q  <= '0;
      begin_q <= '0;
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      mask_q  <= mask_d;
      begin_q <= begin_d;
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  // Next-state: latch completions, advance head over done stages, run the watchdog.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    mask_d    = mask_q;
    begin_d   = begin_q;
    wd_d      = wd_q;
    error_d   = error_q;
    new_head  = head_q;
    scan_stop = 1'b0;
    wd_inc    = wd_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        begin_d = '0;
        // abort in the same cycle cancels the request.
        if (seq_io.start && !seq_io.abort) begin
          state_d = S_RUN;
          head_d  = '0;
          mask_d  = '0;
          wd_d    = '0;
          error_d = 1'b0;
          begin_d = armed_set(4'd0);
        end
      end

      S_RUN: begin
        if (seq_io.abort) begin
          state_d = S_IDLE;
          begin_d = '0;
        end else begin
          // Only armed stages can complete; early completes of head+1 are kept.
          mask_d = mask_q | (seq_io.layer_complete & armed_set(head_q));

          // Skip every consecutive done stage from the head; head stops at the
          // last stage so cur_layer stays a valid index after the final completion.
          for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i >= int'(head_q) && !scan_stop) begin
              if (mask_d[i] && i < NUM_LAYERS - 1) begin
                new_head = 4'(i + 1);
              end else begin
                scan_stop = 1'b1;
              end
            end
          end

          if (&mask_d) begin
            state_d = S_FIN;
            head_d  = new_head;
            wd_d    = '0;
            begin_d = '0;
          end else if (new_head != head_q) begin
            // Progress beats a simultaneous watchdog expiry.
            head_d  = new_head;
            wd_d    = '0;
            begin_d = armed_set(new_head) & ~mask_d;
          end else if (wd_inc >= TIMEOUT) begin
            state_d = S_ERR;
            wd_d    = wd_inc;
            begin_d = '0;
            error_d = 1'b1;
          end else begin
            wd_d    = wd_inc;
            begin_d = armed_set(head_q) & ~mask_d;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        begin_d = '0;
      end

      S_ERR: begin
        state_d = S_IDLE;
        begin_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        begin_d = '0;
      end
    endcase
  end

  assign seq_io.layer_begin = begin_q;
  assign seq_io.cur_layer   = head_q;
  assign seq_io.busy        = (state_q == S_RUN);
  assign seq_io.done        = (state_q == S_FIN);
  assign seq_io.error       = error_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: 4 stages, overlap on, 50-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Every expected value below is hand-derived from the intended behaviour.
module tb_layer_sequencer;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  layer_sequencer_if #(.NUM_LAYERS(4)) bus ();

  layer_sequencer #(
    .NUM_LAYERS (4),
    .OVERLAP    (1),
    .TO_W       (20),
    .TIMEOUT    (20'd50)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .seq_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_complete(input logic [3:0] v);
    bus.layer_complete = v;
    tick();
    bus.layer_complete = 4'b0000;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_beg [4];
    logic [3:0] exp_cur [4];
    logic [3:0] onehot;
    exp_beg = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    exp_cur = '{4'd1, 4'd2, 4'd3, 4'd3};
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.layer_complete = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_begin", 32'(bus.layer_begin), 32'h0);
    check("rst_cur",   32'(bus.cur_layer),   32'h0);
    check("rst_busy",  32'(bus.busy),        32'h0);
    check("rst_done",  32'(bus.done),        32'h0);
    check("rst_error", 32'(bus.error),       32'h0);

    // 1: full in-order run, head completes 10 cycles after each begin change
    do_start();
    check("t1_first_begin", 32'(bus.layer_begin), 32'h3);
    check("t1_busy",        32'(bus.busy),        32'h1);
    check("t1_cur0",        32'(bus.cur_layer),   32'h0);
    for (int s = 0; s < 4; s++) begin
      repeat (9) tick();
      onehot = 4'b0001 << s;
      pulse_complete(onehot);
      check("t1_begin", 32'(bus.layer_begin), 32'(exp_beg[s]));
      check("t1_cur",   32'(bus.cur_layer),   32'(exp_cur[s]));
    end
    check("t1_done_pulse", 32'(bus.done), 32'h1);
    check("t1_fin_busy",   32'(bus.busy), 32'h0);
    tick();
    check("t1_done_one_cycle", 32'(bus.done),      32'h0);
    check("t1_cur_hold",       32'(bus.cur_layer), 32'h3);
    tick();
    check("t1_idle_done", 32'(bus.done), 32'h0);

    // 2: stage 1 completes before stage 0; unarmed and start-while-busy ignored
    do_start();
    check("t2_begin0", 32'(bus.layer_begin), 32'h3);
    pulse_complete(4'b0010);
    check("t2_early_begin", 32'(bus.layer_begin), 32'h1);
    check("t2_early_cur",   32'(bus.cur_layer),   32'h0);
    bus.start = 1'b1;
    pulse_complete(4'b1000);
    bus.start = 1'b0;
    check("t2_unarmed_begin", 32'(bus.layer_begin), 32'h1);
    check("t2_unarmed_busy",  32'(bus.busy),        32'h1);
    pulse_complete(4'b0001);
    check("t2_jump_begin", 32'(bus.layer_begin), 32'hC);
    check("t2_jump_cur",   32'(bus.cur_layer),   32'h2);
    pulse_complete(4'b0100);
    check("t2_stage3_begin", 32'(bus.layer_begin), 32'h8);
    check("t2_stage3_busy",  32'(bus.busy),        32'h1);
    pulse_complete(4'b1000);
    check("t2_done", 32'(bus.done), 32'h1);
    tick();

    // 3: stage 2 never completes -> watchdog error 50 cycles after head reaches 2
    do_start();
    pulse_complete(4'b0011);
    check("t3_head2", 32'(bus.cur_layer), 32'h2);
    repeat (49) tick();
    check("t3_pre_busy",  32'(bus.busy),        32'h1);
    check("t3_pre_error", 32'(bus.error),       32'h0);
    check("t3_pre_begin", 32'(bus.layer_begin), 32'hC);
    tick();
    check("t3_error", 32'(bus.error),       32'h1);
    check("t3_begin", 32'(bus.layer_begin), 32'h0);
    check("t3_busy",  32'(bus.busy),        32'h0);
    check("t3_done",  32'(bus.done),        32'h0);
    tick();
    check("t3_error_sticky", 32'(bus.error), 32'h1);
    tick();
    do_start();
    check("t3_error_clr", 32'(bus.error), 32'h0);
    check("t3_restart",   32'(bus.busy),  32'h1);

    // 4: abort 3 cycles into stage 1, then a complete restart
    pulse_complete(4'b0001);
    check("t4_stage1", 32'(bus.layer_begin), 32'h6);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t4_abort_begin", 32'(bus.layer_begin), 32'h0);
    check("t4_abort_busy",  32'(bus.busy),        32'h0);
    check("t4_abort_done",  32'(bus.done),        32'h0);
    tick();
    check("t4_no_done", 32'(bus.done), 32'h0);
    do_start();
    check("t4_restart_begin", 32'(bus.layer_begin), 32'h3);
    check("t4_restart_cur",   32'(bus.cur_layer),   32'h0);
    for (int s = 0; s < 4; s++) begin
      tick();
      onehot = 4'b0001 << s;
      pulse_complete(onehot);
      check("t4_begin", 32'(bus.layer_begin), 32'(exp_beg[s]));
    end
    check("t4_done", 32'(bus.done), 32'h1);
    tick();

    // start and abort together in IDLE: start ignored
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy",  32'(bus.busy),        32'h0);
    check("abort_start_begin", 32'(bus.layer_begin), 32'h0);

    // 5: reset mid-run with completes held high
    do_start();
    pulse_complete(4'b0001);
    check("t5_stage1", 32'(bus.cur_layer), 32'h1);
    bus.layer_complete = 4'b1111;
    rst = 1'b1;
    tick();
    check("t5_rst_begin", 32'(bus.layer_begin), 32'h0);
    check("t5_rst_cur",   32'(bus.cur_layer),   32'h0);
    check("t5_rst_busy",  32'(bus.busy),        32'h0);
    check("t5_rst_done",  32'(bus.done),        32'h0);
    check("t5_rst_error", 32'(bus.error),       32'h0);
    rst = 1'b0;
    tick();
    check("t5_idle_busy",  32'(bus.busy),        32'h0);
    check("t5_idle_begin", 32'(bus.layer_begin), 32'h0);
    bus.layer_complete = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
